// File: rtl/pc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pc_pkg                                                        |
// | Purpose  : Shared definitions for the program-counter unit: handler      |
// |            state encoding, default reset/exception vectors, sequential   |
// |            increment and an alignment helper.                            |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package pc_pkg;

   typedef enum logic [0:0] {
      ST_NORMAL = 1'b0,
      ST_EXC    = 1'b1
   } pc_state_e;

   localparam logic [31:0] RESET_VEC = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC   = 32'h0000_4180;
   localparam int unsigned PC_INC    = 4;

   // Instruction addresses must be word aligned.
   function automatic logic is_misaligned(input logic [1:0] lsb);
      return (lsb != 2'b00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pc_ctrl_if                                                    |
// | Purpose  : Redirect/fetch bundle between the pipeline (master) and the   |
// |            program-counter unit (slave).                                 |
// | Ports    : master drives en, br_taken/br_target, ras_push/ras_push_addr, |
// |            ras_pop, exc_req/exc_pc, eret; slave drives pcAddr, epc,      |
// |            in_exc, ras_empty, ras_underflow, align_err.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface pc_ctrl_if #(
   parameter int PC_W = 32
);
   import pc_pkg::*;

   logic            en;
   logic            br_taken;
   logic [PC_W-1:0] br_target;
   logic            ras_push;
   logic [PC_W-1:0] ras_push_addr;
   logic            ras_pop;
   logic            exc_req;
   logic [PC_W-1:0] exc_pc;
   logic            eret;

   logic [PC_W-1:0] pcAddr;
   logic [PC_W-1:0] epc;
   logic            in_exc;
   logic            ras_empty;
   logic            ras_underflow;
   logic            align_err;

   modport master (
      output en, br_taken, br_target, ras_push, ras_push_addr, ras_pop,
             exc_req, exc_pc, eret,
      input  pcAddr, epc, in_exc, ras_empty, ras_underflow, align_err
   );

   modport slave (
      input  en, br_taken, br_target, ras_push, ras_push_addr, ras_pop,
             exc_req, exc_pc, eret,
      output pcAddr, epc, in_exc, ras_empty, ras_underflow, align_err
   );

endinterface
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pc_ras                                                        |
// | Purpose  : Circular return-address stack with top pointer and a count    |
// |            saturating at RAS_DEPTH; pushing when full overwrites the     |
// |            oldest entry.                                                 |
// | Ports    : Clk, Reset (async, active-high); push_i, pop_i, push_addr_i   |
// |            (already qualified by the caller); top_o, empty_o, full_o,    |
// |            underflow_o (registered one-cycle pulse).                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pc_ras
   import pc_pkg::*;
#(
   parameter int PC_W      = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [PC_W-1:0] push_addr_i,
   output logic [PC_W-1:0] top_o,
   output logic            empty_o,
   output logic            full_o,
   output logic            underflow_o
);

   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             underflow_q, underflow_d;
   logic [PC_W-1:0]  mem_q [RAS_DEPTH];

   logic             wr_en;
   logic [PTR_W-1:0] wr_idx;
   logic             pop_ok;

   assign empty_o     = (cnt_q == '0);
   assign full_o      = (cnt_q == CNT_W'(RAS_DEPTH));
   assign top_o       = mem_q[ptr_q];
   assign underflow_o = underflow_q;
   assign pop_ok      = pop_i && !empty_o;

   always_comb begin
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      wr_en       = 1'b0;
      wr_idx      = ptr_q;
      underflow_d = pop_i && empty_o;
      if (push_i && pop_ok) begin
         // Simultaneous push/pop: the popped top is replaced in place.
         wr_en = 1'b1;
      end else if (push_i) begin
         // Pointer wraps naturally (power-of-two depth), so a push on a
         // full stack lands on the oldest entry.
         ptr_d  = ptr_q + PTR_W'(1);
         wr_idx = ptr_q + PTR_W'(1);
         wr_en  = 1'b1;
         if (!full_o) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (pop_ok) begin
         ptr_d = ptr_q - PTR_W'(1);
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ptr_q       <= '0;
         cnt_q       <= '0;
         underflow_q <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is never read while empty, so it carries no reset.
   always_ff @(posedge Clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= push_addr_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pc_ctrl                                                       |
// | Purpose  : Fetch program counter with next-PC selection (exception,      |
// |            stall, exception return, RAS pop, branch, +4), EPC capture    |
// |            and handler-state tracking.                                   |
// | Ports    : Clk, Reset (async, active-high); bus (pc_ctrl_if.slave)       |
// |            carrying redirect requests in and pcAddr/epc/status out.      |
// | Config   : define PC_ALIGN_CHECK_EN to trap misaligned redirect targets  |
// |            to the exception vector and pulse align_err.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pc_ctrl #(
   parameter int              PC_W      = 32,
   parameter logic [PC_W-1:0] RESET_VEC = PC_W'(pc_pkg::RESET_VEC),
   parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(pc_pkg::EXC_VEC),
   parameter int              RAS_DEPTH = 4
) (
   input  logic      Clk,
   input  logic      Reset,
   pc_ctrl_if.slave  bus
);
   import pc_pkg::*;

   pc_state_e       state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] epc_q, epc_d;

   logic            eret_ok;
   logic            adv;
   logic            pop_req;
   logic            push_req;
   logic            pop_ok;
   logic [PC_W-1:0] target;
   logic            align_fault;

   logic [PC_W-1:0] ras_top;
   logic            ras_empty;
   logic            ras_underflow;

   // exc_req overrides everything, so nothing else advances in its cycle.
   assign adv      = bus.en && !bus.exc_req;
   assign eret_ok  = bus.eret && (state_q == ST_EXC);
   assign push_req = adv && bus.ras_push;
   // A winning eret masks the pop entirely (no underflow either).
   assign pop_req  = adv && !eret_ok && bus.ras_pop;
   assign pop_ok   = pop_req && !ras_empty;

   pc_ras #(
      .PC_W      (PC_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .Clk         (Clk),
      .Reset       (Reset),
      .push_i      (push_req),
      .pop_i       (pop_req),
      .push_addr_i (bus.ras_push_addr),
      .top_o       (ras_top),
      .empty_o     (ras_empty),
      .full_o      (),
      .underflow_o (ras_underflow)
   );

   // Redirect source selection below the exception/stall levels.
   always_comb begin
      target = pc_q + PC_W'(PC_INC);
      if (eret_ok) begin
         target = epc_q;
      end else if (pop_ok) begin
         target = ras_top;
      end else if (bus.br_taken) begin
         target = bus.br_target;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   logic redirect;
   logic align_q;

   // The +4 path keeps alignment, so only real redirects are checked.
   assign redirect    = eret_ok || pop_ok || bus.br_taken;
   assign align_fault = redirect && is_misaligned(target[1:0]);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         align_q <= 1'b0;
      end else begin
         align_q <= adv && align_fault;
      end
   end

   assign bus.align_err = align_q;
`else
   assign align_fault   = 1'b0;
   assign bus.align_err = 1'b0;
`endif

   always_comb begin
      pc_d    = pc_q;
      epc_d   = epc_q;
      state_d = state_q;
      if (bus.exc_req) begin
         pc_d    = EXC_VEC;
         state_d = ST_EXC;
         // A nested exception keeps the original return address.
         if (state_q == ST_NORMAL) begin
            epc_d = bus.exc_pc;
         end
      end else if (bus.en) begin
         if (align_fault) begin
            pc_d    = EXC_VEC;
            state_d = ST_EXC;
            if (state_q == ST_NORMAL) begin
               epc_d = target;
            end
         end else begin
            pc_d = target;
            if (eret_ok) begin
               state_d = ST_NORMAL;
            end
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pc_q    <= RESET_VEC;
         epc_q   <= '0;
         state_q <= ST_NORMAL;
      end else begin
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         state_q <= state_d;
      end
   end

   assign bus.pcAddr        = pc_q;
   assign bus.epc           = epc_q;
   assign bus.in_exc        = (state_q == ST_EXC);
   assign bus.ras_empty     = ras_empty;
   assign bus.ras_underflow = ras_underflow;

endmodule
`default_nettype wire
